// File: rtl/interboard_pkg.sv
// interboard_pkg
// Definitions shared by both ends of the inter-board Request/Ack link.
// It holds the frame geometry, the field layout of the 24-bit game message,
// the receiver state encoding, and the pack/unpack helpers. The frame sender
// on the other board uses the same package so that both ends pack the
// message identically.
package interboard_pkg;

  localparam int FRAME_W  = 24;
  localparam int CHUNK_W  = 6;
  localparam int N_CHUNKS = 4;

  // Field widths
  localparam int MSG_TYPE_W = 4;
  localparam int CARD_W     = 6;
  localparam int SEL_LEN_W  = 3;
  localparam int BLOCK_X_W  = 5;
  localparam int BLOCK_Y_W  = 3;
  localparam int MOVE_DIR_W = 1;

  // Bit offsets (LSB) of each field within the 24-bit frame
  localparam int MOVE_DIR_LSB = 0;
  localparam int BLOCK_Y_LSB  = 1;
  localparam int BLOCK_X_LSB  = 4;
  localparam int SEL_LEN_LSB  = 9;
  localparam int CARD_LSB     = 12;
  localparam int MSG_TYPE_LSB = 18;
  localparam int TAG_LSB      = 22;
  localparam int MSG_W        = 22;

  typedef enum logic {
    S_WAIT_REQ = 1'b0,
    S_WAIT_REL = 1'b1
  } rx_state_e;

  // Field order matches frame[21:0], MSB first.
  typedef struct packed {
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [CARD_W-1:0]     card;
    logic [SEL_LEN_W-1:0]  sel_len;
    logic [BLOCK_X_W-1:0]  block_x;
    logic [BLOCK_Y_W-1:0]  block_y;
    logic [MOVE_DIR_W-1:0] move_dir;
  } game_msg_t;

  // Two leading zero bits keep chunk0 away from the all-ones abort pattern.
  function automatic logic [FRAME_W-1:0] pack_frame(input game_msg_t m);
    return {2'b00, m};
  endfunction

  function automatic game_msg_t frame_to_msg(input logic [FRAME_W-1:0] f);
    return game_msg_t'(f[MSG_W-1:0]);
  endfunction

  function automatic logic frame_tag_ok(input logic [FRAME_W-1:0] f);
    return (f[FRAME_W-1:TAG_LSB] == 2'b00);
  endfunction

endpackage

// File: rtl/interboard_frame_receiver_sync.sv
// sync_2ff
// Brings one asynchronous input bit into the clk domain through two flops.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/interboard_frame_receiver.sv
// interboard_frame_receiver
// This is the receiving end of the 4-phase Request/Ack inter-board link. It
// captures four 6-bit chunks, acknowledges each one, and reassembles the
// 24-bit game message. When a complete, valid frame has been received, it
// publishes the decoded fields together with a one-cycle interboard_en pulse.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   interboard_rst         synchronous abort (remote all-ones pattern)
//   Request_in             async sender strobe
//   inter_data_in[5:0]     chunk data, stable while Request_in is high
//   Ack_out                registered acknowledge
//   interboard_en          one-cycle pulse with a valid frame
//   interboard_*           decoded fields, held until the next valid frame
//   frame_err              one-cycle pulse when a frame is discarded
//   busy                   mid-frame indicator
module interboard_frame_receiver #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       interboard_rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [3:0] interboard_msg_type,
  output logic [5:0] interboard_card,
  output logic [2:0] interboard_sel_len,
  output logic [4:0] interboard_block_x,
  output logic [2:0] interboard_block_y,
  output logic       interboard_move_dir,
  output logic       frame_err,
  output logic       busy
);

  import interboard_pkg::*;

  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam int              CC_W       = $clog2(N_CHUNKS);
  localparam logic [CC_W-1:0] LAST_CHUNK = CC_W'(N_CHUNKS - 1);
  localparam logic [CC_W-1:0] CC_ZERO    = {CC_W{1'b0}};

  logic               req_s;
  rx_state_e          state_r;
  rx_state_e          state_nxt_s;
  logic [CC_W-1:0]    chunk_cnt_r;
  logic [CC_W-1:0]    chunk_cnt_nxt_s;
  logic [FRAME_W-1:0] asm_r;
  logic [CNT_W-1:0]   to_cnt_r;
  logic               seen_low_r;
  logic               ack_r;
  logic               en_r;
  logic               err_r;
  logic               busy_r;
  game_msg_t          msg_r;
  logic               capture_s;
  logic               release_s;
  logic               timeout_s;
  logic               to_active_s;
  logic               frame_done_s;
  logic               frame_ok_s;

  sync_2ff u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Request_in),
    .q     (req_s)
  );

  assign to_active_s  = (state_r == S_WAIT_REL) || (chunk_cnt_r != CC_ZERO);
  assign frame_done_s = release_s && (chunk_cnt_r == LAST_CHUNK);
  assign frame_ok_s   = frame_tag_ok(asm_r);

  // Handshake FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_WAIT_REQ;
      chunk_cnt_r <= CC_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      chunk_cnt_r <= chunk_cnt_nxt_s;
    end
  end

  // Next-state logic: abort beats timeout, timeout beats handshake progress
  always_comb begin
    state_nxt_s     = state_r;
    chunk_cnt_nxt_s = chunk_cnt_r;
    capture_s       = 1'b0;
    release_s       = 1'b0;
    timeout_s       = 1'b0;
    if (interboard_rst) begin
      state_nxt_s     = S_WAIT_REQ;
      chunk_cnt_nxt_s = CC_ZERO;
    end else if (to_active_s && (to_cnt_r == TO_LAST)) begin
      timeout_s       = 1'b1;
      state_nxt_s     = S_WAIT_REQ;
      chunk_cnt_nxt_s = CC_ZERO;
    end else begin
      case (state_r)
        S_WAIT_REQ: begin
          // A request left high across an abort/timeout must drop first
          if (req_s && seen_low_r) begin
            capture_s   = 1'b1;
            state_nxt_s = S_WAIT_REL;
          end else begin
            state_nxt_s = S_WAIT_REQ;
          end
        end
        S_WAIT_REL: begin
          if (!req_s) begin
            release_s   = 1'b1;
            state_nxt_s = S_WAIT_REQ;
            if (chunk_cnt_r == LAST_CHUNK) begin
              chunk_cnt_nxt_s = CC_ZERO;
            end else begin
              chunk_cnt_nxt_s = chunk_cnt_r + CC_W'(1);
            end
          end else begin
            state_nxt_s = S_WAIT_REL;
          end
        end
        default: begin
          state_nxt_s     = S_WAIT_REQ;
          chunk_cnt_nxt_s = CC_ZERO;
        end
      endcase
    end
  end

  // Assembly shift register, fed MSB chunk first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r <= {FRAME_W{1'b0}};
    end else if (capture_s) begin
      asm_r <= {asm_r[FRAME_W-CHUNK_W-1:0], inter_data_in};
    end
  end

  // Mid-frame watchdog; restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if (interboard_rst || !to_active_s || (state_nxt_s != state_r)) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end
  end

  // Tracks whether the synchronized request has been low since the last abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_low_r <= 1'b0;
    end else if (interboard_rst || timeout_s) begin
      seen_low_r <= 1'b0;
    end else if (!req_s) begin
      seen_low_r <= 1'b1;
    end
  end

  // Acknowledge, pulses, busy flag and held message fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r  <= 1'b0;
      en_r   <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
      msg_r  <= game_msg_t'({MSG_W{1'b0}});
    end else begin
      en_r   <= frame_done_s && frame_ok_s;
      err_r  <= timeout_s || (frame_done_s && !frame_ok_s);
      busy_r <= (state_nxt_s == S_WAIT_REL) || (chunk_cnt_nxt_s != CC_ZERO);
      if (interboard_rst || timeout_s) begin
        ack_r <= 1'b0;
      end else if (capture_s) begin
        ack_r <= 1'b1;
      end else if (release_s) begin
        ack_r <= 1'b0;
      end
      if (frame_done_s && frame_ok_s) begin
        msg_r <= frame_to_msg(asm_r);
      end
    end
  end

  assign Ack_out             = ack_r;
  assign interboard_en       = en_r;
  assign frame_err           = err_r;
  assign busy                = busy_r;
  assign interboard_msg_type = msg_r.msg_type;
  assign interboard_card     = msg_r.card;
  assign interboard_sel_len  = msg_r.sel_len;
  assign interboard_block_x  = msg_r.block_x;
  assign interboard_block_y  = msg_r.block_y;
  assign interboard_move_dir = msg_r.move_dir;

endmodule

// File: tb/tb_interboard_frame_receiver.sv
// Directed bench for interboard_frame_receiver with hand-computed frames.
// Frame A chunks 05 21 14 19 -> type 5, card 33, sel 2, x 17, y 4, dir 1
// Frame B chunks 03 0A 39 14 -> type 3, card 10, sel 7, x 5,  y 2, dir 0
module tb_interboard_frame_receiver;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       interboard_rst = 1'b0;
  logic       Request_in = 1'b0;
  logic [5:0] inter_data_in = 6'h00;
  logic       Ack_out;
  logic       interboard_en;
  logic [3:0] interboard_msg_type;
  logic [5:0] interboard_card;
  logic [2:0] interboard_sel_len;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y;
  logic       interboard_move_dir;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int en_total = 0;
  int err_total = 0;
  int en_long = 0;
  logic en_prev = 1'b0;

  interboard_frame_receiver #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .interboard_rst      (interboard_rst),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_card     (interboard_card),
    .interboard_sel_len  (interboard_sel_len),
    .interboard_block_x  (interboard_block_x),
    .interboard_block_y  (interboard_block_y),
    .interboard_move_dir (interboard_move_dir),
    .frame_err           (frame_err),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (interboard_en) en_total <= en_total + 1;
    if (frame_err) err_total <= err_total + 1;
    if (interboard_en && en_prev) en_long <= en_long + 1;
    en_prev <= interboard_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_chunk(input logic [5:0] d, output int lr, output int lf,
                            output logic en_fall);
    inter_data_in = d;
    Request_in = 1'b1;
    lr = 0;
    do begin @(negedge clk); lr++; end while (!Ack_out && lr < 20);
    if (!Ack_out) lr = -1;
    Request_in = 1'b0;
    lf = 0;
    do begin @(negedge clk); lf++; end while (Ack_out && lf < 20);
    if (Ack_out) lf = -1;
    en_fall = interboard_en;
  endtask

  task automatic send_frame(input string tag, input logic [5:0] c0, input logic [5:0] c1,
                            input logic [5:0] c2, input logic [5:0] c3,
                            output int acks, output logic en_last);
    logic [5:0] ch [4];
    int lr;
    int lf;
    logic ef;
    ch = '{c0, c1, c2, c3};
    acks = 0;
    en_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_chunk(ch[i], lr, lf, ef);
      if (lr > 0) acks++;
      chk({tag, " rise_lat"}, lr, 3);
      chk({tag, " fall_lat"}, lf, 3);
      if (i < 3) chk({tag, " early_en"}, int'(ef), 0);
      else en_last = ef;
    end
  endtask

  task automatic chk_fields(input string tag, input int mt, input int cd, input int sl,
                            input int bx, input int by, input int md);
    chk({tag, " msg_type"}, int'(interboard_msg_type), mt);
    chk({tag, " card"}, int'(interboard_card), cd);
    chk({tag, " sel_len"}, int'(interboard_sel_len), sl);
    chk({tag, " block_x"}, int'(interboard_block_x), bx);
    chk({tag, " block_y"}, int'(interboard_block_y), by);
    chk({tag, " move_dir"}, int'(interboard_move_dir), md);
  endtask

  initial begin
    int acks;
    int n;
    int e0;
    int r0;
    int lr;
    int lf;
    logic ef;
    logic en_last;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst ack", int'(Ack_out), 0);
    chk("rst en", int'(interboard_en), 0);
    chk("rst err", int'(frame_err), 0);
    chk("rst busy", int'(busy), 0);
    chk_fields("rst", 0, 0, 0, 0, 0, 0);

    // Valid frame A
    e0 = en_total; r0 = err_total;
    send_frame("A", 6'h05, 6'h21, 6'h14, 6'h19, acks, en_last);
    @(negedge clk);
    chk("A acks", acks, 4);
    chk("A en_with_last_fall", int'(en_last), 1);
    chk("A en_count", en_total - e0, 1);
    chk("A err_count", err_total - r0, 0);
    chk("A busy", int'(busy), 0);
    chk_fields("A", 5, 33, 2, 17, 4, 1);

    // Bad leading bits: discarded, fields hold
    e0 = en_total; r0 = err_total;
    send_frame("bad", 6'h25, 6'h21, 6'h14, 6'h19, acks, en_last);
    @(negedge clk);
    chk("bad en_last", int'(en_last), 0);
    chk("bad err_count", err_total - r0, 1);
    chk("bad en_count", en_total - e0, 0);
    chk_fields("bad hold", 5, 33, 2, 17, 4, 1);

    // Timeout after two chunks
    e0 = en_total; r0 = err_total;
    send_chunk(6'h03, lr, lf, ef);
    send_chunk(6'h0A, lr, lf, ef);
    chk("to busy_mid", int'(busy), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_err && n < 200);
    chk("to cycles", n, TO);
    chk("to busy", int'(busy), 0);
    chk("to ack", int'(Ack_out), 0);
    @(negedge clk);
    chk("to err_count", err_total - r0, 1);
    chk("to en_count", en_total - e0, 0);
    send_frame("B1", 6'h03, 6'h0A, 6'h39, 6'h14, acks, en_last);
    @(negedge clk);
    chk("B1 en_last", int'(en_last), 1);
    chk_fields("B1", 3, 10, 7, 5, 2, 0);

    // interboard_rst mid-frame with Request_in high
    send_chunk(6'h05, lr, lf, ef);
    send_chunk(6'h21, lr, lf, ef);
    e0 = en_total; r0 = err_total;
    inter_data_in = 6'h14;
    Request_in = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!Ack_out && n < 20);
    chk("abort ack_before", int'(Ack_out), 1);
    interboard_rst = 1'b1;
    @(negedge clk);
    interboard_rst = 1'b0;
    chk("abort ack", int'(Ack_out), 0);
    chk("abort busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    chk("abort no_recapture", int'(Ack_out), 0);
    Request_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort en_count", en_total - e0, 0);
    chk("abort err_count", err_total - r0, 0);
    send_frame("A2", 6'h05, 6'h21, 6'h14, 6'h19, acks, en_last);
    @(negedge clk);
    chk("A2 en_last", int'(en_last), 1);
    chk_fields("A2", 5, 33, 2, 17, 4, 1);

    // Asynchronous reset while Ack_out is high
    inter_data_in = 6'h03;
    Request_in = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!Ack_out && n < 20);
    chk("arst ack_before", int'(Ack_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst ack", int'(Ack_out), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst en", int'(interboard_en), 0);
    chk("arst err", int'(frame_err), 0);
    chk_fields("arst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    Request_in = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    e0 = en_total;
    send_frame("B2", 6'h03, 6'h0A, 6'h39, 6'h14, acks, en_last);
    @(negedge clk);
    chk("B2 en_last", int'(en_last), 1);
    chk("B2 en_count", en_total - e0, 1);
    chk_fields("B2", 3, 10, 7, 5, 2, 0);

    chk("en width", en_long, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
